alu_seq: RTL

//  Parametrised, registered successor to the combinational 6502 ALU.
//  - Adds: generic WIDTH, SUB and rotate ops, a full flag set (C,V,Z,N), and an iterative unsigned MUL.
//  - Uses a valid/ready handshake on input and output.
//  - Sits between the decode/register-file stage and the result writeback in the datapath.

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_mul_iter.sv | 53 +++++
 rtl/alu_seq.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: op codes, flag bit positions, FSM state encoding and flag packing
// helper for alu_seq. Optional decimal mode is enabled with ALU_DECIMAL_EN.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_LSR = 4'd5;
  localparam logic [3:0] OP_ASL = 4'd6;
  localparam logic [3:0] OP_ROR = 4'd7;
  localparam logic [3:0] OP_ROL = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_N = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
`ifdef ALU_DECIMAL_EN
    ST_DEC_ADJ = 2'd3,
`endif
    ST_HOLD    = 2'd2
  } state_t;

  function automatic logic [3:0] pack_flags(input logic n, input logic v,
                                            input logic z, input logic c);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_V] = v;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative unsigned shift-add multiplier. One partial-product
// step per cycle for WIDTH cycles after load. The next product is exposed
// combinationally so the caller can capture the final step on the edge
// where 'last' is high.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   add;

  // Add multiplicand when the multiplier LSB is set, then shift the pair right
  always_comb begin
    add     = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    prod_hi = add[WIDTH:1];
    prod_lo = {add[0], lo[WIDTH-1:1]};
    last    = (count == CW'(1));
  end

  // Load operands, then step until the counter drains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      count <= '0;
    end else if (load) begin
      mcand <= a;
      hi    <= '0;
      lo    <= b;
      count <= CW'(WIDTH);
    end else if (count != '0) begin
      hi    <= prod_hi;
      lo    <= prod_lo;
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshake, full N/V/Z/C flags and
// an iterative multiplier. Define ALU_DECIMAL_EN for packed-BCD ADD/SUB,
// which adds one DEC_ADJ cycle of latency.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             dec_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_hi,
  output logic [3:0]       flags
);

  state_t           state;
  logic             accept;
  logic             is_mul, is_sub, is_arith;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] c_res;
  logic             c_c, c_v;
  logic             mul_last;
  logic [WIDTH-1:0] mul_hi, mul_lo;

  assign in_ready  = (state == ST_IDLE) | ((state == ST_HOLD) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == ST_HOLD);

  // Single-cycle operations and their carry/overflow
  always_comb begin
    c_res    = '0;
    c_c      = 1'b0;
    c_v      = 1'b0;
    is_mul   = 1'b0;
    is_sub   = 1'b0;
    is_arith = 1'b0;
    b_eff    = b;
    sum      = '0;
    case (op)
      OPW'(OP_SUB): begin is_sub = 1'b1; is_arith = 1'b1; end
      OPW'(OP_AND): c_res = a & b;
      OPW'(OP_OR):  c_res = a | b;
      OPW'(OP_XOR): c_res = a ^ b;
      OPW'(OP_LSR): begin c_res = a >> 1; c_c = a[0]; end
      OPW'(OP_ASL): begin c_res = a << 1; c_c = a[WIDTH-1]; end
      OPW'(OP_ROR): {c_res, c_c} = {carry_in, a};
      OPW'(OP_ROL): {c_c, c_res} = {a, carry_in};
      OPW'(OP_MUL): is_mul = 1'b1;
      default:      is_arith = 1'b1;
    endcase
    if (is_arith) begin
      b_eff = is_sub ? ~b : b;
      sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_in};
      c_res = sum[WIDTH-1:0];
      c_c   = sum[WIDTH];
      c_v   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (c_res[WIDTH-1] != a[WIDTH-1]);
    end
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept & is_mul),
    .a       (a),
    .b       (b),
    .last    (mul_last),
    .prod_hi (mul_hi),
    .prod_lo (mul_lo)
  );

`ifdef ALU_DECIMAL_EN
  logic [WIDTH-1:0] dq_a, dq_b;
  logic             dq_c, dq_sub;
  logic [WIDTH:0]   dec_out;

  // Packed-BCD add/subtract; MSB of the return is carry / no-borrow
  function automatic logic [WIDTH:0] bcd_op(input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] y,
                                            input logic cin, input logic sub);
    logic [WIDTH-1:0] r;
    logic             cy;
    logic [4:0]       s;
    r  = '0;
    cy = cin;
    for (int unsigned i = 0; i < WIDTH / 4; i++) begin
      if (!sub) begin
        s = {1'b0, x[4*i +: 4]} + {1'b0, y[4*i +: 4]} + {4'b0, cy};
        if (s > 5'd9) begin s = s + 5'd6; cy = 1'b1; end
        else cy = 1'b0;
      end else begin
        s = {1'b0, x[4*i +: 4]} - {1'b0, y[4*i +: 4]} - {4'b0, ~cy};
        if (s[4]) begin s = s - 5'd6; cy = 1'b0; end
        else cy = 1'b1;
      end
      r[4*i +: 4] = s[3:0];
    end
    return {cy, r};
  endfunction

  // Decimal correction of the operands captured at accept
  always_comb begin
    dec_out = bcd_op(dq_a, dq_b, dq_c, dq_sub);
  end

  // Capture operands for the DEC_ADJ cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq_a   <= '0;
      dq_b   <= '0;
      dq_c   <= 1'b0;
      dq_sub <= 1'b0;
    end else if (accept) begin
      dq_a   <= a;
      dq_b   <= b;
      dq_c   <= carry_in;
      dq_sub <= is_sub;
    end
  end
`else
  logic unused_dec;
  assign unused_dec = dec_in;
`endif

  // Control FSM and result/flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      res    <= '0;
      res_hi <= '0;
      flags  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (accept) begin
            if (is_mul) begin
              state <= ST_MUL_RUN;
            end else begin
              res    <= c_res;
              res_hi <= '0;
              flags  <= pack_flags(c_res[WIDTH-1], c_v, (c_res == '0), c_c);
`ifdef ALU_DECIMAL_EN
              state  <= (dec_in && is_arith) ? ST_DEC_ADJ : ST_HOLD;
`else
              state  <= ST_HOLD;
`endif
            end
          end else if (state == ST_HOLD && out_ready) begin
            state <= ST_IDLE;
          end
        end
        ST_MUL_RUN: begin
          if (mul_last) begin
            state  <= ST_HOLD;
            res    <= mul_lo;
            res_hi <= mul_hi;
            flags  <= pack_flags(mul_lo[WIDTH-1], 1'b0,
                                 (mul_lo == '0) && (mul_hi == '0), |mul_hi);
          end
        end
`ifdef ALU_DECIMAL_EN
        // N and V stay from the binary result captured at accept
        ST_DEC_ADJ: begin
          state         <= ST_HOLD;
          res           <= dec_out[WIDTH-1:0];
          flags[FLAG_C] <= dec_out[WIDTH];
          flags[FLAG_Z] <= (dec_out[WIDTH-1:0] == '0);
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
